// File: rtl/strobe_period_meter_if.sv
// Strobe period meter bus: strobe/clear inputs and the measurement outputs.
// master drives the strobe and clear lines; slave is the meter itself.
interface strobe_period_meter_if #(
   parameter int BW = 8
);
   logic          strb_i;
   logic          clear_i;
   logic [BW-1:0] period_o;
   logic          period_valid_o;
   logic          locked_o;
   logic          timeout_o;

   modport master (
      output strb_i,
      output clear_i,
      input  period_o,
      input  period_valid_o,
      input  locked_o,
      input  timeout_o
   );

   modport slave (
      input  strb_i,
      input  clear_i,
      output period_o,
      output period_valid_o,
      output locked_o,
      output timeout_o
   );
endinterface

// File: rtl/strobe_period_meter.sv
// Strobe period meter: counts clk_i cycles between successive strobes,
// reports each measured period, flags lock after LOCK_CNT identical
// periods in a row and flags a sticky timeout when strobes stop.
//
// Optional build macro STRB_METER_EDGE_EN: a strobe is the rising edge of
// strb_i instead of its level, so a held-high strb_i counts only once.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no reference strobe yet (after reset, clear or timeout)
// MEAS   | counting since the last strobe, lock not (yet) reached
// LOCKED | last LOCK_CNT measured periods were identical
module strobe_period_meter #(
   parameter int BW       = 8,
   parameter int LOCK_CNT = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   strobe_period_meter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEAS   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [BW-1:0] CNT_MAX  = '1;
   localparam logic [BW-1:0] CNT_ONE  = BW'(1);
   localparam logic [3:0]    LOCK_MAX = 4'(LOCK_CNT);

   state_t        state_q, state_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] period_q, period_d;
   logic [3:0]    match_q, match_d;
   logic          valid_q, valid_d;
   logic          locked_q, locked_d;
   logic          timeout_q, timeout_d;

   logic          strobe;
   logic          same_period;
   logic [3:0]    match_inc;

`ifdef STRB_METER_EDGE_EN
   logic strb_q, strb_d;

   // Delayed copy of strb_i for rising-edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         strb_q <= 1'b0;
      end else begin
         strb_q <= strb_d;
      end
   end

   assign strb_d = bus.clear_i ? 1'b0 : bus.strb_i;
   assign strobe = bus.strb_i & ~strb_q;
`else
   assign strobe = bus.strb_i;
`endif

   // A non-zero match count doubles as "a previous period exists in this run";
   // it is 0 only between the first strobe and the first report.
   assign same_period = (match_q != 4'd0) && (cnt_q == period_q);
   assign match_inc   = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + 4'd1;

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         match_q   <= 4'd0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic: clear wins over everything, then strobe, then counting.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;

      if (bus.clear_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         period_d  = '0;
         match_d   = 4'd0;
         locked_d  = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (strobe) begin
                  cnt_d     = CNT_ONE;
                  timeout_d = 1'b0;
                  state_d   = MEAS;
               end
            end

            MEAS, LOCKED: begin
               if (strobe) begin
                  // A strobe at cnt == CNT_MAX is still a valid measurement.
                  period_d = cnt_q;
                  valid_d  = 1'b1;
                  cnt_d    = CNT_ONE;
                  match_d  = same_period ? match_inc : 4'd1;
                  locked_d = (match_d == LOCK_MAX);
                  state_d  = locked_d ? LOCKED : MEAS;
               end else if (cnt_q == CNT_MAX) begin
                  // Strobes stopped: drop lock, keep the last period visible.
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  match_d   = 4'd0;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            default: begin
               state_d  = IDLE;
               cnt_d    = '0;
               match_d  = 4'd0;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.period_o       = period_q;
   assign bus.period_valid_o = valid_q;
   assign bus.locked_o       = locked_q;
   assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Directed bench for strobe_period_meter (BW=8, LOCK_CNT=3). Builds with or
// without STRB_METER_EDGE_EN; only the held-strobe expectations differ.
module tb_strobe_period_meter;
   localparam int BW = 8;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   total = 0;
   int   bad   = 0;

   strobe_period_meter_if #(.BW(BW)) bus ();

   strobe_period_meter #(.BW(BW), .LOCK_CNT(3)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // {period_valid, locked, timeout, period}
   wire [BW+2:0] obs = {bus.period_valid_o, bus.locked_o, bus.timeout_o, bus.period_o};

   function automatic logic [BW+2:0] pack(input logic v, input logic l, input logic t,
                                           input logic [BW-1:0] p);
      return {v, l, t, p};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_strobe();
      bus.strb_i = 1'b1;
      tick(1);
      bus.strb_i = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear_i = 1'b1;
      tick(1);
      bus.clear_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [BW+2:0] exp;
      rst_i = 1'b1;
      tick(2);
      exp = pack(0, 0, 0, 0);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL reset: got=%h want=%h", obs, exp);
      end
      rst_i = 1'b0;
      tick(2);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL reset_release: got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_lock10();
      logic [BW+2:0] exp;
      do_clear();
      do_strobe();
      exp = pack(0, 0, 0, 0);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL lock10_first: got=%h want=%h", obs, exp);
      end
      for (int k = 2; k <= 4; k++) begin
         tick(9);
         do_strobe();
         exp = pack(1, (k == 4), 0, 8'd10);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL lock10_rpt%0d: got=%h want=%h", k, obs, exp);
         end
      end
      tick(1);
      exp = pack(0, 1, 0, 8'd10);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL lock10_valid_pulse: got=%h want=%h", obs, exp);
      end
   endtask

   // Continues from lock at 10 (one edge already past the last strobe).
   task automatic test_relock7();
      logic [BW+2:0] exp;
      tick(5);
      do_strobe();
      exp = pack(1, 0, 0, 8'd7);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL relock7_break: got=%h want=%h", obs, exp);
      end
      for (int i = 0; i < 2; i++) begin
         tick(6);
         do_strobe();
         exp = pack(1, (i == 1), 0, 8'd7);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL relock7_rpt%0d: got=%h want=%h", i + 2, obs, exp);
         end
      end
   endtask

   // Continues from lock at 7; the last strobe is t0.
   task automatic test_timeout();
      logic [BW+2:0] exp;
      tick(254);
      exp = pack(0, 1, 0, 8'd7);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL timeout_t255: got=%h want=%h", obs, exp);
      end
      tick(1);
      exp = pack(0, 0, 1, 8'd7);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL timeout_t256: got=%h want=%h", obs, exp);
      end
      tick(3);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL timeout_sticky: got=%h want=%h", obs, exp);
      end
      do_strobe();
      exp = pack(0, 0, 0, 8'd7);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL timeout_next_strobe: got=%h want=%h", obs, exp);
      end
   endtask

   // Continues from the first strobe after timeout.
   task automatic test_max_period();
      logic [BW+2:0] exp;
      tick(254);
      exp = pack(0, 0, 0, 8'd7);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL max_cnt255_no_timeout: got=%h want=%h", obs, exp);
      end
      do_strobe();
      exp = pack(1, 0, 0, 8'd255);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL max_rpt1: got=%h want=%h", obs, exp);
      end
      for (int i = 0; i < 2; i++) begin
         tick(254);
         do_strobe();
         exp = pack(1, (i == 1), 0, 8'd255);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL max_rpt%0d: got=%h want=%h", i + 2, obs, exp);
         end
      end
   endtask

   task automatic test_clear_with_strobe();
      logic [BW+2:0] exp;
      do_clear();
      do_strobe();
      for (int k = 0; k < 3; k++) begin
         tick(9);
         do_strobe();
      end
      exp = pack(1, 1, 0, 8'd10);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL clr_prelock: got=%h want=%h", obs, exp);
      end
      tick(9);
      bus.strb_i  = 1'b1;
      bus.clear_i = 1'b1;
      tick(1);
      bus.strb_i  = 1'b0;
      bus.clear_i = 1'b0;
      exp = pack(0, 0, 0, 0);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL clr_with_strobe: got=%h want=%h", obs, exp);
      end
      tick(3);
      do_strobe();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL clr_first_strobe: got=%h want=%h", obs, exp);
      end
      tick(9);
      do_strobe();
      exp = pack(1, 0, 0, 8'd10);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL clr_second_strobe: got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_held_strobe();
      logic [BW+2:0] exp;
      do_clear();
      bus.strb_i = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
`ifdef STRB_METER_EDGE_EN
         exp = pack(0, 0, 0, 0);
`else
         exp = (k == 1) ? pack(0, 0, 0, 0) : pack(1, (k >= 4), 0, 8'd1);
`endif
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL held_cycle%0d: got=%h want=%h", k, obs, exp);
         end
      end
      bus.strb_i = 1'b0;
      tick(4);
      do_strobe();
`ifdef STRB_METER_EDGE_EN
      exp = pack(1, 0, 0, 8'd9);
`else
      exp = pack(1, 0, 0, 8'd5);
`endif
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL held_after_release: got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_async_reset();
      logic [BW+2:0] exp;
      do_clear();
      do_strobe();
      for (int k = 0; k < 3; k++) begin
         tick(9);
         do_strobe();
      end
      tick(4);
      exp = pack(0, 1, 0, 8'd10);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL arst_prelock: got=%h want=%h", obs, exp);
      end
      #2;
      rst_i = 1'b1;
      #1;
      exp = pack(0, 0, 0, 0);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL arst_async: got=%h want=%h", obs, exp);
      end
      #2;
      rst_i = 1'b0;
      tick(2);
      do_strobe();
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL arst_first_strobe: got=%h want=%h", obs, exp);
      end
      tick(9);
      do_strobe();
      exp = pack(1, 0, 0, 8'd10);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL arst_second_strobe: got=%h want=%h", obs, exp);
      end
   endtask

   initial begin
      bus.strb_i  = 1'b0;
      bus.clear_i = 1'b0;
      test_reset();
      test_lock10();
      test_relock7();
      test_timeout();
      test_max_period();
      test_clear_with_strobe();
      test_held_strobe();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
